escaner_digitos: RTL and testbench

Upstream scan controller for the 4:1 nibble multiplexer in the display path. Holds a coherent 16-bit display value and presents it as four nibbles on the multiplexer's data inputs. Steps the 2-bit select through digits 0..3 at a prescaled rate. Drives the matching active-low digit anodes, with inter-digit ghost blanking and optional leading-zero blanking; new values are committed only at frame boundaries.

---
 rtl/escaner_pkg.sv | 39 +++
 rtl/escaner_digitos_divisor_tick.sv | 48 ++++
 rtl/escaner_digitos.sv | 121 ++++++++++++
 tb/tb_escaner_digitos.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/escaner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : escaner_pkg
//  Description : Shared types, constants and helpers for the digit scanner.
//  Revision    : 1.0  initial release
// ============================================================================
package escaner_pkg;

    localparam int N_DIGITOS = 4;
    localparam int SEL_W     = 2;
    localparam int NIBBLE_W  = 4;

    localparam logic [N_DIGITOS-1:0] ANODO_OFF = 4'b1111;

    // Four display nibbles; element k is digit k.
    typedef logic [N_DIGITOS-1:0][NIBBLE_W-1:0] datos_t;

    // A digit k >= 1 is a leading zero when nibbles k..top are all zero.
    function automatic logic lz_blanco(input datos_t d, input logic [SEL_W-1:0] sel);
        logic ceros;
        logic res;
        ceros = 1'b1;
        res   = 1'b0;
        for (int k = N_DIGITOS - 1; k >= 1; k--) begin
            ceros = ceros & (d[k] == '0);
            if (sel == SEL_W'(k)) begin
                res = ceros;
            end
        end
        return res;
    endfunction

    // Active-low one-hot anode pattern for a given digit.
    function automatic logic [N_DIGITOS-1:0] anodo_on(input logic [SEL_W-1:0] sel);
        return ~(N_DIGITOS'(1) << sel);
    endfunction

endpackage
`default_nettype wire

// File: rtl/escaner_digitos_divisor_tick.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_tick
//  Description : Enabled modulo-DIV counter. Exposes the next count value and
//                a wrap pulse asserted in the cycle before the count returns
//                to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module divisor_tick #(
    parameter int DIV = 8,
    parameter int W   = $clog2(DIV)
) (
    input  logic         i_Clk,
    input  logic         i_Rst_n,
    input  logic         i_En,
    output logic [W-1:0] o_Cuenta_Sig,
    output logic         o_Wrap
);

    localparam logic [W-1:0] c_MAX = W'(DIV - 1);

    logic [W-1:0] cuenta_q;
    logic [W-1:0] cuenta_d;

    // Next count: wrap at DIV-1, hold while disabled.
    always_comb begin
        o_Wrap   = i_En && (cuenta_q == c_MAX);
        cuenta_d = cuenta_q;
        if (o_Wrap) begin
            cuenta_d = '0;
        end else if (i_En) begin
            cuenta_d = cuenta_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign o_Cuenta_Sig = cuenta_d;

endmodule
`default_nettype wire

// File: rtl/escaner_digitos.sv
`default_nettype none
// ============================================================================
//  Module      : escaner_digitos
//  Description : Scan controller for a 4:1 nibble display multiplexer. Steps
//                the digit select at a prescaled rate, drives active-low
//                anodes with ghost and leading-zero blanking, and commits new
//                display values only at frame boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module escaner_digitos
    import escaner_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_En,
    input  logic                 i_Load,
    input  logic [15:0]          i_Valor,
    input  logic                 i_Lz_Blank,
    output logic [NIBBLE_W-1:0]  o_Datos_0,
    output logic [NIBBLE_W-1:0]  o_Datos_1,
    output logic [NIBBLE_W-1:0]  o_Datos_2,
    output logic [NIBBLE_W-1:0]  o_Datos_3,
    output logic [SEL_W-1:0]     o_Sel,
    output logic [N_DIGITOS-1:0] o_Anodo,
    output logic                 o_Tick,
    output logic                 o_Pend
);

    localparam int               CNT_W   = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] c_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0]     w_cuenta_sig;
    logic                 w_wrap;
    logic                 w_frontera;
    logic                 w_commit;

    logic [SEL_W-1:0]     sel_q,   sel_d;
    logic [N_DIGITOS-1:0] anodo_q, anodo_d;
    logic                 tick_q;
    logic                 pend_q,  pend_d;
    datos_t               datos_q, datos_d;
    datos_t               valor_q, valor_d;

    divisor_tick #(
        .DIV (PRESCALE),
        .W   (CNT_W)
    ) u_divisor (
        .i_Clk        (i_Clk),
        .i_Rst_n      (i_Rst_n),
        .i_En         (i_En),
        .o_Cuenta_Sig (w_cuenta_sig),
        .o_Wrap       (w_wrap)
    );

    // Next-state: digit advance, pending/commit handoff, anode pattern for the
    // state that will be current after this edge.
    always_comb begin
        sel_d   = sel_q;
        datos_d = datos_q;
        valor_d = valor_q;
        pend_d  = pend_q;

        w_frontera = w_wrap && (sel_q == SEL_W'(N_DIGITOS - 1));
        // While scanning, commits wait for the frame boundary; while stopped
        // there is no frame, so a pending value goes out immediately.
        w_commit   = pend_q && (i_En ? w_frontera : 1'b1);

        if (w_wrap) begin
            sel_d = sel_q + SEL_W'(1);
        end
        if (w_commit) begin
            datos_d = valor_q;
            pend_d  = 1'b0;
        end
        // A load on the commit edge becomes the next pending value.
        if (i_Load) begin
            valor_d = i_Valor;
            pend_d  = 1'b1;
        end

        if (!i_En || (w_cuenta_sig < c_BLANK) ||
            (i_Lz_Blank && lz_blanco(datos_d, sel_d))) begin
            anodo_d = ANODO_OFF;
        end else begin
            anodo_d = anodo_on(sel_d);
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sel_q   <= '0;
            anodo_q <= ANODO_OFF;
            tick_q  <= 1'b0;
            pend_q  <= 1'b0;
            datos_q <= '0;
            valor_q <= '0;
        end else begin
            sel_q   <= sel_d;
            anodo_q <= anodo_d;
            tick_q  <= w_wrap;
            pend_q  <= pend_d;
            datos_q <= datos_d;
            valor_q <= valor_d;
        end
    end

    assign o_Sel     = sel_q;
    assign o_Anodo   = anodo_q;
    assign o_Tick    = tick_q;
    assign o_Pend    = pend_q;
    assign o_Datos_0 = datos_q[0];
    assign o_Datos_1 = datos_q[1];
    assign o_Datos_2 = datos_q[2];
    assign o_Datos_3 = datos_q[3];

endmodule
`default_nettype wire

// File: tb/tb_escaner_digitos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_escaner_digitos
//  Description : Scoreboard bench for escaner_digitos (PRESCALE=8,
//                BLANK_CYCLES=2). Expected slot starts are queued; a monitor
//                checks each o_Tick against the queue head.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_escaner_digitos;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] valor;
    logic        lz;
    logic [3:0]  d0, d1, d2, d3;
    logic [1:0]  sel;
    logic [3:0]  anodo;
    logic        tick;
    logic        pend;

    int n_checks = 0;
    int n_errors = 0;
    int n_edge   = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] datos;
        logic        pend;
        logic [3:0]  an;
    } exp_t;

    exp_t sb[$];

    escaner_digitos #(
        .PRESCALE     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_En       (en),
        .i_Load     (load),
        .i_Valor    (valor),
        .i_Lz_Blank (lz),
        .o_Datos_0  (d0),
        .o_Datos_1  (d1),
        .o_Datos_2  (d2),
        .o_Datos_3  (d3),
        .o_Sel      (sel),
        .o_Anodo    (anodo),
        .o_Tick     (tick),
        .o_Pend     (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edge <= 0;
        else        n_edge <= n_edge + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [1:0] s, input logic [15:0] d,
                                 input logic p, input logic [3:0] a);
        exp_t e;
        e.sel = s; e.datos = d; e.pend = p; e.an = a;
        sb.push_back(e);
    endfunction

    // Return at the first negedge after rising edge k has happened.
    task automatic tras_flanco(input int k);
        while (n_edge < k) @(negedge clk);
    endtask

    // One-cycle load strobe sampled on edge k.
    task automatic cargar(input int k, input logic [15:0] v);
        tras_flanco(k - 1);
        load  = 1'b1;
        valor = v;
        tras_flanco(k);
        load  = 1'b0;
    endtask

    // Monitor: each tick pops one expected slot start.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && tick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tick", 16'd1, 16'd0);
                end else begin
                    e = sb.pop_front();
                    chk("tick_sel",   {14'd0, sel}, {14'd0, e.sel});
                    chk("tick_datos", {d3, d2, d1, d0}, e.datos);
                    chk("tick_pend",  {15'd0, pend}, {15'd0, e.pend});
                    chk("blank_c0",   {12'd0, anodo}, 16'h000F);
                    @(negedge clk);
                    chk("tick_width", {15'd0, tick}, 16'd0);
                    chk("blank_c1",   {12'd0, anodo}, 16'h000F);
                    @(negedge clk);
                    chk("anodo_lit",  {12'd0, anodo}, {12'd0, e.an});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; load = 1'b0; valor = 16'h0; lz = 1'b0;

        // Frame 0: empty display
        push(1, 16'h0000, 0, 4'b1101); push(2, 16'h0000, 0, 4'b1011);
        push(3, 16'h0000, 0, 4'b0111); push(0, 16'h0000, 0, 4'b1110);
        // Frame 1: 1234 loaded mid slot 1
        push(1, 16'h0000, 0, 4'b1101); push(2, 16'h0000, 1, 4'b1011);
        push(3, 16'h0000, 1, 4'b0111); push(0, 16'h1234, 0, 4'b1110);
        // Frame 2: AAAA then 5555, last wins
        push(1, 16'h1234, 1, 4'b1101); push(2, 16'h1234, 1, 4'b1011);
        push(3, 16'h1234, 1, 4'b0111); push(0, 16'h5555, 0, 4'b1110);
        // Frame 3: 1111 pending, BEEF loaded on the boundary
        push(1, 16'h5555, 1, 4'b1101); push(2, 16'h5555, 1, 4'b1011);
        push(3, 16'h5555, 1, 4'b0111); push(0, 16'h1111, 1, 4'b1110);
        // Frame 4: BEEF commits one frame later
        push(1, 16'h1111, 1, 4'b1101); push(2, 16'h1111, 1, 4'b1011);
        push(3, 16'h1111, 1, 4'b0111); push(0, 16'hBEEF, 0, 4'b1110);
        // Frame 5: LZ on, BEEF has no leading zeros, 0007 pending
        push(1, 16'hBEEF, 1, 4'b1101); push(2, 16'hBEEF, 1, 4'b1011);
        push(3, 16'hBEEF, 1, 4'b0111); push(0, 16'h0007, 0, 4'b1110);
        // Frame 6: 0007 blanks digits 1..3, 0000 loaded
        push(1, 16'h0007, 0, 4'b1111); push(2, 16'h0007, 0, 4'b1111);
        push(3, 16'h0007, 0, 4'b1111); push(0, 16'h0000, 0, 4'b1110);
        // Frame 7: 0000, only digit 0 lit
        push(1, 16'h0000, 0, 4'b1111); push(2, 16'h0000, 0, 4'b1111);
        push(3, 16'h0000, 0, 4'b1111); push(0, 16'h0000, 0, 4'b1110);
        // After pause/resume
        push(1, 16'h4321, 0, 4'b1101);
        // After async reset: pending 9999 lost
        push(1, 16'h0000, 0, 4'b1101);

        @(negedge clk);
        chk("rst_sel",   {14'd0, sel}, 16'd0);
        chk("rst_anodo", {12'd0, anodo}, 16'h000F);
        chk("rst_tick",  {15'd0, tick}, 16'd0);
        chk("rst_pend",  {15'd0, pend}, 16'd0);
        chk("rst_datos", {d3, d2, d1, d0}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        tras_flanco(1);
        chk("e1_anodo", {12'd0, anodo}, 16'h000F);
        tras_flanco(2);
        chk("e2_anodo", {12'd0, anodo}, 16'h000E);
        chk("e2_sel",   {14'd0, sel}, 16'd0);

        cargar(43, 16'h1234);
        chk("load_pend",  {15'd0, pend}, 16'd1);
        chk("load_datos", {d3, d2, d1, d0}, 16'h0000);
        cargar(70,  16'hAAAA);
        cargar(90,  16'h5555);
        cargar(100, 16'h1111);
        cargar(128, 16'hBEEF);
        tras_flanco(160);
        lz = 1'b1;
        cargar(165, 16'h0007);
        cargar(218, 16'h0000);

        // Pause mid-slot
        tras_flanco(259);
        en = 1'b0;
        tras_flanco(260);
        chk("dis_sel",   {14'd0, sel}, 16'd0);
        chk("dis_anodo", {12'd0, anodo}, 16'h000F);
        chk("dis_tick",  {15'd0, tick}, 16'd0);
        cargar(262, 16'h4321);
        chk("dis_pend",  {15'd0, pend}, 16'd1);
        chk("dis_hold",  {d3, d2, d1, d0}, 16'h0000);
        tras_flanco(263);
        chk("dis_commit", {d3, d2, d1, d0}, 16'h4321);
        chk("dis_pend0",  {15'd0, pend}, 16'd0);
        tras_flanco(265);
        chk("dis_sel_hold", {14'd0, sel}, 16'd0);
        chk("dis_an_hold",  {12'd0, anodo}, 16'h000F);
        en = 1'b1;
        tras_flanco(266);
        chk("reen_anodo", {12'd0, anodo}, 16'h000E);

        // Asynchronous reset mid-slot with a value pending
        cargar(272, 16'h9999);
        chk("pre_rst_pend", {15'd0, pend}, 16'd1);
        tras_flanco(273);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel",   {14'd0, sel}, 16'd0);
        chk("arst_anodo", {12'd0, anodo}, 16'h000F);
        chk("arst_tick",  {15'd0, tick}, 16'd0);
        chk("arst_pend",  {15'd0, pend}, 16'd0);
        chk("arst_datos", {d3, d2, d1, d0}, 16'h0000);
        @(negedge clk);
        lz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        tras_flanco(12);
        chk("sb_drained", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
